// File: rtl/wb_select_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_reg_pkg
// Description : Shared writeback-select state type and source-index names.
// Revision    : 1.0  initial release
// ============================================================================
package wb_select_reg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SRC = 2'd1,
        HOLD     = 2'd2
    } wb_state_t;

    localparam int unsigned SRC_ALU     = 0;
    localparam int unsigned SRC_DMEM    = 1;
    localparam int unsigned SRC_LUT_LSW = 2;
    localparam int unsigned SRC_LUT_MSW = 3;
    localparam int unsigned SRC_IMM     = 4;

endpackage
`default_nettype wire

// File: rtl/wb_select_reg.sv
`default_nettype none
// ============================================================================
// Module      : wb_select_reg
// Description : Registered N-way writeback source select with valid/ready
//               output handshake and per-request source timeout.
// Revision    : 1.0  initial release
// ============================================================================
module wb_select_reg
    import wb_select_reg_pkg::*;
#(
    parameter int  W           = 8,
    parameter int  N           = 5,
    parameter int  DEFAULT_SRC = 0,
    parameter int  TIMEOUT     = 15,
    localparam int SEL_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*W-1:0]     src_data,
    input  logic [N-1:0]       src_valid,
    input  logic [SEL_W-1:0]   sel,
    input  logic               req,
    input  logic               wb_ready,
    output logic [W-1:0]       dataOut,
    output logic               dataOut_valid,
    output logic               stall,
    output logic               sel_err,
    output logic               timeout
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W:0]     c_N_EXT   = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0]   c_DEF_SEL = SEL_W'(DEFAULT_SRC);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    wb_state_t            r_state, w_state_nxt;
    logic [W-1:0]         r_data, w_data_nxt;
    logic [SEL_W-1:0]     r_sel_q, w_sel_q_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_sel_err, w_sel_err_nxt;
    logic                 r_timeout, w_timeout_nxt;

    logic [W-1:0]         w_src [N];
    logic                 w_sel_ok;
    logic [SEL_W-1:0]     w_eff_sel;
    logic                 w_stall;
    logic                 w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_src[gi] = src_data[gi*W +: W];
        end
    endgenerate

    assign w_sel_ok  = ({1'b0, sel} < c_N_EXT);
    assign w_eff_sel = w_sel_ok ? sel : c_DEF_SEL;
    assign w_stall   = (r_state == WAIT_SRC) || ((r_state == HOLD) && !wb_ready);
    assign w_accept  = req && !w_stall;

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_sel_q_nxt   = r_sel_q;
        w_cnt_nxt     = r_cnt;
        w_sel_err_nxt = 1'b0;
        w_timeout_nxt = r_timeout;

        // An accept from HOLD is the back-to-back case: no IDLE bubble.
        if (w_accept) begin
            w_sel_q_nxt   = w_eff_sel;
            w_sel_err_nxt = !w_sel_ok;
            w_timeout_nxt = 1'b0;
            w_cnt_nxt     = '0;
            if (src_valid[w_eff_sel]) begin
                w_data_nxt  = w_src[w_eff_sel];
                w_state_nxt = HOLD;
            end else begin
                w_state_nxt = WAIT_SRC;
            end
        end else begin
            case (r_state)
                WAIT_SRC: begin
                    if (src_valid[r_sel_q]) begin
                        w_data_nxt  = w_src[r_sel_q];
                        w_state_nxt = HOLD;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_data_nxt    = '0;
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = HOLD;
                    end else if (r_cnt < c_TO_LAST) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (wb_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_sel_q   <= c_DEF_SEL;
            r_cnt     <= '0;
            r_sel_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_sel_q   <= w_sel_q_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel_err <= w_sel_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign dataOut       = r_data;
    assign dataOut_valid = (r_state == HOLD);
    assign stall         = w_stall;
    assign sel_err       = r_sel_err;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_select_reg
// Description : Directed bench for wb_select_reg against a request-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_select_reg;
    import wb_select_reg_pkg::*;

    localparam int W       = 8;
    localparam int N       = 5;
    localparam int SEL_W   = 3;
    localparam int DEF_SRC = 0;
    localparam int TO      = 15;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [N*W-1:0]   src_data = '0;
    logic [N-1:0]     src_valid = '0;
    logic [SEL_W-1:0] sel = '0;
    logic             req = 1'b0;
    logic             wb_ready = 1'b1;
    logic [W-1:0]     dataOut;
    logic             dataOut_valid;
    logic             stall;
    logic             sel_err;
    logic             timeout;

    int n_vec = 0;
    int n_err = 0;

    wb_select_reg #(
        .W(W), .N(N), .DEFAULT_SRC(DEF_SRC), .TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Reset(Reset), .src_data(src_data), .src_valid(src_valid),
        .sel(sel), .req(req), .wb_ready(wb_ready), .dataOut(dataOut),
        .dataOut_valid(dataOut_valid), .stall(stall), .sel_err(sel_err),
        .timeout(timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: one outstanding request, either holding a result
    // or waiting on its source with an age in cycles.
    logic         m_hold = 1'b0;
    logic         m_wait = 1'b0;
    int           m_age = 0;
    logic [W-1:0] m_data = '0;
    int           m_sel = DEF_SRC;
    logic         m_to = 1'b0;
    logic         m_err = 1'b0;

    always @(posedge Clk or posedge Reset) begin : model
        int s;
        bit acc;
        if (Reset) begin
            m_hold <= 1'b0; m_wait <= 1'b0; m_age <= 0; m_data <= '0;
            m_sel <= DEF_SRC; m_to <= 1'b0; m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            acc = req && !(m_wait || (m_hold && !wb_ready));
            if (acc) begin
                s = (int'(sel) < N) ? int'(sel) : DEF_SRC;
                m_err <= (int'(sel) >= N);
                m_to  <= 1'b0;
                m_age <= 0;
                m_sel <= s;
                if (src_valid[s]) begin
                    m_data <= src_data[s*W +: W];
                    m_hold <= 1'b1; m_wait <= 1'b0;
                end else begin
                    m_hold <= 1'b0; m_wait <= 1'b1;
                end
            end else if (m_wait) begin
                if (src_valid[m_sel]) begin
                    m_data <= src_data[m_sel*W +: W];
                    m_wait <= 1'b0; m_hold <= 1'b1;
                end else if (m_age + 1 == TO) begin
                    m_data <= '0; m_to <= 1'b1;
                    m_wait <= 1'b0; m_hold <= 1'b1;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_hold && wb_ready) begin
                m_hold <= 1'b0;
            end
        end
    end

    always @(negedge Clk) begin : compare
        chk("cmp dataOut", 32'(dataOut), 32'(m_data));
        chk("cmp dataOut_valid", 32'(dataOut_valid), 32'(m_hold));
        chk("cmp stall", 32'(stall), 32'(m_wait || (m_hold && !wb_ready)));
        chk("cmp sel_err", 32'(sel_err), 32'(m_err));
        chk("cmp timeout", 32'(timeout), 32'(m_to));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [W-1:0] v);
        src_data[idx*W +: W] = v;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #1 Reset = 1'b0;
        chk("reset dataOut", 32'(dataOut), 32'h0);
        chk("reset valid", 32'(dataOut_valid), 32'h0);
        chk("reset stall", 32'(stall), 32'h0);
        chk("reset timeout", 32'(timeout), 32'h0);

        // Immediate source, latency 1, then back to idle.
        src_valid = 5'b11111;
        set_word(SRC_IMM, 8'h5A);
        sel = SEL_W'(SRC_IMM); req = 1'b1; wb_ready = 1'b1;
        tick();
        req = 1'b0;
        chk("imm dataOut", 32'(dataOut), 32'h5A);
        chk("imm valid", 32'(dataOut_valid), 32'h1);
        chk("imm stall", 32'(stall), 32'h0);
        tick();
        chk("imm idle valid", 32'(dataOut_valid), 32'h0);

        // Slow memory: three stalled cycles before valid.
        src_valid = 5'b11101;
        set_word(SRC_DMEM, 8'hC3);
        sel = SEL_W'(SRC_DMEM); req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("slow stall", 32'(stall), 32'h1);
            if (i < 2) tick();
        end
        src_valid[SRC_DMEM] = 1'b1;
        tick();
        chk("slow dataOut", 32'(dataOut), 32'hC3);
        chk("slow valid", 32'(dataOut_valid), 32'h1);
        chk("slow timeout", 32'(timeout), 32'h0);
        tick();

        // Timeout after TO wait cycles; held with wb_ready low.
        src_valid[SRC_DMEM] = 1'b0;
        sel = SEL_W'(SRC_DMEM); req = 1'b1; wb_ready = 1'b0;
        tick();
        req = 1'b0;
        repeat (TO - 1) tick();
        chk("to still waiting", 32'(stall), 32'h1);
        tick();
        chk("to dataOut", 32'(dataOut), 32'h0);
        chk("to valid", 32'(dataOut_valid), 32'h1);
        chk("to flag", 32'(timeout), 32'h1);
        tick();
        chk("to sticky", 32'(timeout), 32'h1);
        sel = SEL_W'(SRC_IMM); req = 1'b1; wb_ready = 1'b1;
        tick();
        req = 1'b0;
        chk("to cleared", 32'(timeout), 32'h0);
        chk("to next data", 32'(dataOut), 32'h5A);
        tick();

        // Backpressure with a held request, then back-to-back accept.
        src_valid = 5'b11111;
        sel = SEL_W'(SRC_IMM); req = 1'b1; wb_ready = 1'b0;
        tick();
        set_word(SRC_ALU, 8'h11);
        sel = SEL_W'(SRC_ALU);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp held data", 32'(dataOut), 32'h5A);
            chk("bp stall", 32'(stall), 32'h1);
        end
        wb_ready = 1'b1;
        #1 chk("bp stall drops", 32'(stall), 32'h0);
        tick();
        req = 1'b0;
        chk("b2b data", 32'(dataOut), 32'h11);
        chk("b2b valid", 32'(dataOut_valid), 32'h1);
        tick();

        // Out-of-range select falls back to the default source.
        set_word(SRC_ALU, 8'h22);
        sel = 3'd7; req = 1'b1;
        tick();
        req = 1'b0;
        chk("oor sel_err", 32'(sel_err), 32'h1);
        chk("oor data", 32'(dataOut), 32'h22);
        tick();
        chk("oor pulse end", 32'(sel_err), 32'h0);

        // Asynchronous reset while waiting on a source.
        src_valid[SRC_DMEM] = 1'b0;
        sel = SEL_W'(SRC_DMEM); req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        #2 Reset = 1'b1;
        #1;
        chk("arst valid", 32'(dataOut_valid), 32'h0);
        chk("arst stall", 32'(stall), 32'h0);
        chk("arst timeout", 32'(timeout), 32'h0);
        chk("arst dataOut", 32'(dataOut), 32'h0);
        @(negedge Clk);
        #1 Reset = 1'b0;
        src_valid = 5'b11111;
        set_word(SRC_LUT_LSW, 8'h3C);
        sel = SEL_W'(SRC_LUT_LSW); req = 1'b1;
        tick();
        req = 1'b0;
        chk("fresh data", 32'(dataOut), 32'h3C);
        chk("fresh valid", 32'(dataOut_valid), 32'h1);
        chk("fresh sel_err", 32'(sel_err), 32'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_select_reg.md
Name: wb_select_reg

Overview:
Parametrised, registered successor to the 8-bit writeback source mux.
- Selects one of N source buses, waits for that source's data to become valid, and registers the result.
- Holds the result under a valid/ready handshake toward the register file.
- Sits between the execute/memory sources (ALU, data memory, LUT halves, immediate, ...) and the register-file write port.
- Replaces pure combinational selection so multi-cycle sources can stall writeback cleanly.

Parameters:
- W, 8, data width of each source and of the output.
- N, 5, number of sources.
- SEL_W, $clog2(N) (3 at default), select width; derived, not overridden.
- DEFAULT_SRC, 0, source index used when the select code is out of range.
- TIMEOUT, 15, maximum cycles spent waiting for a source before giving up; must be ≥1.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- src_data  input  N*W  packed source buses; source i occupies bits [i*W +: W].
- src_valid  input  N  per-source data-valid; combinational sources tie high.
- sel  input  SEL_W  source select code, sampled on an accepted req.
- req  input  1  writeback request for the current instruction.
- wb_ready  input  1  register file accepts dataOut this cycle.
- dataOut  output  W  registered selected data.
- dataOut_valid  output  1  dataOut holds a result not yet accepted.
- stall  output  1  upstream must hold req/sel; the request is not accepted.
- sel_err  output  1  one-cycle pulse: out-of-range sel was replaced by DEFAULT_SRC.
- timeout  output  1  sticky until the next accepted req: the current result was forced to 0 by timeout.

Behaviour:
- Reset (async, any state): state=IDLE, dataOut=0, dataOut_valid=0, sel_err=0, timeout=0, wait counter=0, sel_q=DEFAULT_SRC. An in-flight request is abandoned, with no partial output.
- Acceptance: req is accepted on a rising edge when stall=0.
- stall = (state==WAIT_SRC) || (state==HOLD && !wb_ready). stall is combinational from state and wb_ready.
- On accept:
  - sel_q <= (sel<N) ? sel : DEFAULT_SRC.
  - sel_err <= (sel>=N) for exactly one cycle.
  - timeout <= 0; wait counter <= 0.
  - If src_valid[eff_sel] is high in the same cycle: dataOut <= source data, go to HOLD, dataOut_valid=1 the next cycle (latency 1).
  - Otherwise go to WAIT_SRC.
- States:
  - IDLE: dataOut_valid=0; dataOut keeps its last value. On accept, go to HOLD or WAIT_SRC as above.
  - WAIT_SRC: each cycle, if src_valid[sel_q]=1, capture data and go to HOLD. Else, if counter==TIMEOUT-1, set dataOut<=0, timeout<=1, go to HOLD. Else counter++.
  - HOLD: dataOut_valid=1 and dataOut stable. If wb_ready && !req, go to IDLE. If wb_ready && req (back-to-back), the new request is accepted in the same edge and the state goes directly to HOLD or WAIT_SRC, with no bubble.
- Data is captured only on the cycle of transition into HOLD. Later changes to src_data or src_valid do not affect the held dataOut.
- Counter width is $clog2(TIMEOUT+1). The counter saturates; it never wraps.
- A src_valid edge arriving on the same cycle as timeout expiry: valid data wins and timeout stays 0.
- req while stall=1 is ignored; the requester holds it.

Decomposition:
- Shared package (processor pkg):
  - wb_state_t enum {IDLE, WAIT_SRC, HOLD}.
  - Named source-index constants SRC_ALU=0, SRC_DMEM=1, SRC_LUT_LSW=2, SRC_LUT_MSW=3, SRC_IMM=4, used by the decoder and the bench.
- No sub-module. The indexed part-select mux is inline; the FSM and counter stay in one always_ff plus one always_comb.

Test Plan:
- Immediate source: sel=4, src_valid=all 1s, src_data[4]=8'h5A, req=1, wb_ready=1 → dataOut=8'h5A, dataOut_valid=1 one cycle later; stall=0 throughout; next cycle IDLE.
- Slow memory: sel=1, src_valid[1]=0 for 3 cycles, then 1 with data 8'hC3 → stall=1 for 3 cycles; dataOut=8'hC3 valid the cycle after src_valid rises; timeout=0.
- Timeout: TIMEOUT=15, sel=1, src_valid[1] never rises → after 15 wait cycles dataOut=0, dataOut_valid=1, timeout=1; timeout clears on the next accepted req.
- Backpressure plus back-to-back: result held with wb_ready=0 for 2 cycles while req held with sel=0 and ALU=8'h11 → dataOut stays at the old value and stall=1. When wb_ready=1, the new req is accepted and dataOut=8'h11 next cycle with no idle bubble.
- Out-of-range select: sel=7, src_data[0]=8'h22 → sel_err pulses 1 cycle; dataOut=8'h22.
- Async reset mid-WAIT_SRC: assert Reset between edges → dataOut_valid, stall, and timeout drop immediately, dataOut=0. After release, the first req behaves as fresh.
